// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle 8-bit shifter/rotator sequenced by a three-state FSM
// Barrel step blocks (0-7 positions) plus the top that walks an effective count down in steps of at most 7.

module shift_sequencer_shl (
  input  logic [7:0] i_data,
  input  logic [2:0] i_step,
  output logic [7:0] o_data
);
  assign o_data = i_data << i_step;
endmodule

module shift_sequencer_shr (
  input  logic [7:0] i_data,
  input  logic [2:0] i_step,
  input  logic       i_fill,
  output logic [7:0] o_data
);
  logic [15:0] w_ext;
  logic [15:0] w_shifted;

  assign w_ext     = {{8{i_fill}}, i_data};
  assign w_shifted = w_ext >> i_step;
  assign o_data    = w_shifted[7:0];
endmodule

module shift_sequencer_ror (
  input  logic [7:0] i_data,
  input  logic [2:0] i_step,
  output logic [7:0] o_data
);
  logic [15:0] w_dbl;
  logic [15:0] w_shifted;

  assign w_dbl     = {i_data, i_data};
  assign w_shifted = w_dbl >> i_step;
  assign o_data    = w_shifted[7:0];
endmodule

module shift_sequencer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] OPCODE,
  input  logic [7:0] DATA,
  input  logic [7:0] AMOUNT,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  state_t     r_state;
  logic [1:0] r_op;
  logic       r_fill;
  logic [7:0] r_work;
  logic [3:0] r_rem;
  logic [7:0] r_result;
  logic       r_busy;
  logic       r_done;

  logic [2:0] w_step;
  logic [3:0] w_rem_next;
  logic [3:0] w_eff;
  logic [7:0] w_shl;
  logic [7:0] w_shr;
  logic [7:0] w_ror;
  logic [7:0] w_next;

  assign w_step     = (r_rem > 4'd7) ? 3'd7 : r_rem[2:0];
  assign w_rem_next = r_rem - {1'b0, w_step};

  // Counts of 8 or more saturate to 8: that already clears (or sign-fills) every bit.
  always_comb begin
    w_eff = 4'd0;
    if (OPCODE == OP_ROR)
      w_eff = {1'b0, AMOUNT[2:0]};
    else if (AMOUNT >= 8'd8)
      w_eff = 4'd8;
    else
      w_eff = AMOUNT[3:0];
  end

  shift_sequencer_shl u_shl (
    .i_data (r_work),
    .i_step (w_step),
    .o_data (w_shl)
  );

  shift_sequencer_shr u_shr (
    .i_data (r_work),
    .i_step (w_step),
    .i_fill (r_fill),
    .o_data (w_shr)
  );

  shift_sequencer_ror u_ror (
    .i_data (r_work),
    .i_step (w_step),
    .o_data (w_ror)
  );

  always_comb begin
    w_next = w_shl;
    case (r_op)
      OP_SLL:  w_next = w_shl;
      OP_SRL:  w_next = w_shr;
      OP_SRA:  w_next = w_shr;
      default: w_next = w_ror;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_fill   <= 1'b0;
      r_work   <= 8'h00;
      r_rem    <= 4'd0;
      r_result <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_work <= w_next;
          r_rem  <= w_rem_next;
          if (w_rem_next == 4'd0) begin
            r_result <= w_next;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        // IDLE and DONE both accept a new request so operations can run back to back.
        default: begin
          r_done <= 1'b0;
          if (START) begin
            r_op   <= OPCODE;
            r_fill <= (OPCODE == OP_SRA) & DATA[7];
            r_work <= DATA;
            r_rem  <= w_eff;
            if (w_eff != 4'd0) begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state  <= S_DONE;
              r_result <= DATA;
              r_done   <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign RESULT = r_result;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer
// Stimulus pushes expected result and DONE cycle; a negedge monitor pops on every DONE pulse.

module tb_shift_sequencer;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [1:0] OPCODE = 2'b00;
  logic [7:0] DATA = 8'h00;
  logic [7:0] AMOUNT = 8'h00;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   dir_checks = 0;
  int   dir_fails = 0;
  int   mon_checks = 0;
  int   mon_fails = 0;

  shift_sequencer dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .OPCODE (OPCODE),
    .DATA   (DATA),
    .AMOUNT (AMOUNT),
    .RESULT (RESULT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET && DONE) begin
        if (sb.size() == 0) begin
          mon_checks++;
          mon_fails++;
          $display("FAIL unexpected_done: got DONE=1 in cycle %0d with RESULT=%02h, required no pulse", cyc, RESULT);
        end else begin
          e = sb.pop_front();
          mon_checks += 2;
          if (RESULT !== e.res) begin
            mon_fails++;
            $display("FAIL result: got %02h required %02h (cycle %0d)", RESULT, e.res, cyc);
          end
          if (cyc != e.cyc) begin
            mon_fails++;
            $display("FAIL done_latency: DONE in cycle %0d required cycle %0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    dir_checks++;
    if (act !== exp) begin
      dir_fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Presents a request for the next edge, then scrambles the inputs to show they are not re-sampled.
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a,
                       input logic [7:0] res, input int lat);
    START  = 1'b1;
    OPCODE = op;
    DATA   = d;
    AMOUNT = a;
    @(posedge CLK);
    #1;
    sb.push_back('{res, cyc + lat});
    START  = 1'b0;
    OPCODE = ~op;
    DATA   = ~d;
    AMOUNT = 8'hFF;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((BUSY || DONE) && n < 30) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 30) begin
      dir_checks++;
      dir_fails++;
      $display("FAIL wait_idle: block still busy after %0d cycles, required idle", n);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2 RESET = 1'b0;
    #1;
    check("reset_result", RESULT, 8'h00);
    check("reset_busy", BUSY, 1'b0);
    check("reset_done", DONE, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;

    issue(SLL, 8'h91, 8'd3, 8'h88, 1);
    check("sll3_busy", BUSY, 1'b1);
    @(posedge CLK); #1;
    check("sll3_busy_clear", BUSY, 1'b0);
    wait_idle();

    issue(SRA, 8'h91, 8'd10, 8'hFF, 2);
    check("sra10_busy", BUSY, 1'b1);
    wait_idle();
    issue(SRL, 8'h91, 8'd200, 8'h00, 2);
    wait_idle();
    issue(SLL, 8'h91, 8'd8, 8'h00, 2);
    wait_idle();
    issue(ROR, 8'h91, 8'd9, 8'hC8, 1);
    wait_idle();
    issue(ROR, 8'h91, 8'd8, 8'h91, 0);
    check("ror8_busy", BUSY, 1'b0);
    wait_idle();
    issue(SLL, 8'h5A, 8'd0, 8'h5A, 0);
    check("zero_busy", BUSY, 1'b0);
    check("zero_done", DONE, 1'b1);
    wait_idle();
    issue(SRA, 8'h71, 8'd3, 8'h0E, 1);
    wait_idle();
    issue(SRA, 8'h80, 8'd7, 8'hFF, 1);
    wait_idle();
    issue(ROR, 8'h91, 8'd5, 8'h8C, 1);
    wait_idle();

    // START held through both SHIFT cycles with different operands must be ignored.
    START = 1'b1; OPCODE = SRA; DATA = 8'h91; AMOUNT = 8'd10;
    @(posedge CLK); #1;
    sb.push_back('{8'hFF, cyc + 2});
    OPCODE = SLL; DATA = 8'h00; AMOUNT = 8'd1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_idle();

    issue(SLL, 8'h91, 8'd3, 8'h88, 1);
    @(posedge CLK); #1;
    check("b2b_done_cycle", DONE, 1'b1);
    issue(SRL, 8'hF0, 8'd4, 8'h0F, 1);
    wait_idle();

    START = 1'b1; OPCODE = SRL; DATA = 8'h91; AMOUNT = 8'd200;
    @(posedge CLK); #1;
    START = 1'b0;
    check("abort_busy_before", BUSY, 1'b1);
    #2 RESET = 1'b0;
    #1;
    check("abort_result", RESULT, 8'h00);
    check("abort_busy", BUSY, 1'b0);
    check("abort_done", DONE, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    issue(SRA, 8'h71, 8'd3, 8'h0E, 1);
    check("first_start_busy", BUSY, 1'b1);
    wait_idle();

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             dir_checks + mon_checks, dir_fails + mon_fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
